// File: rtl/goose_motion_ctrl.sv
// rtl/goose_motion_ctrl.sv - goose state, per-frame jump trajectory, pose, leg animation and distance
// Optional landing jump buffer: define GOOSE_JUMP_BUFFER_EN.
module goose_motion_ctrl #(
  parameter int unsigned GROUND_Y   = 380,
  parameter int unsigned JUMP_V0    = 15,
  parameter int unsigned LEG_FRAMES = 6
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        frame_tick_i,
  input  logic        btn_jump_i,
  input  logic        btn_slide_i,
  input  logic        hit_i,
  input  logic        restart_i,
  output logic [9:0]  goose_y_o,
  output logic [1:0]  pose_o,
  output logic        leg_phase_o,
  output logic        playing_o,
  output logic        game_over_o,
  output logic [15:0] distance_o
);
  localparam int LW = (LEG_FRAMES > 1) ? $clog2(LEG_FRAMES) : 1;
  localparam logic [9:0] GROUND = 10'(GROUND_Y);
  localparam logic signed [5:0] V0 = $signed(6'(JUMP_V0));
  localparam logic [LW-1:0] LEG_LAST = LW'(LEG_FRAMES - 1);

  // Low two bits of the encoding are the pose code; IDLE shows the RUN pose.
  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SLIDE = 3'd1,
    ST_JUMP  = 3'd2,
    ST_DEAD  = 3'd3,
    ST_IDLE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         y_q, y_d;
  logic signed [5:0]  vel_q, vel_d;
  logic [LW-1:0]      leg_cnt_q, leg_cnt_d;
  logic               leg_q, leg_d;
  logic [15:0]        dist_q, dist_d;
  logic               jump_prev_q;
  logic               jump_edge;
  logic signed [10:0] y_next;
  logic               landing;
  logic               rejump;
  logic               adv_dist, adv_leg;

  assign jump_edge = btn_jump_i & ~jump_prev_q;
  assign y_next    = $signed({1'b0, y_q}) - $signed({{5{vel_q[5]}}, vel_q});
  assign landing   = vel_q[5] && (y_next >= $signed({1'b0, GROUND}));

`ifdef GOOSE_JUMP_BUFFER_EN
  localparam logic signed [5:0] BUF_VEL = $signed(6'(3 - int'(JUMP_V0)));
  logic jump_buf_q, jump_buf_d;
  logic buf_set;

  assign buf_set = jump_edge && (vel_q <= BUF_VEL);
  assign rejump  = jump_buf_q | buf_set;

  always_comb begin
    jump_buf_d = jump_buf_q;
    if (state_q == ST_JUMP) begin
      if (hit_i)                         jump_buf_d = 1'b0;
      else if (frame_tick_i && landing)  jump_buf_d = 1'b0;
      else if (buf_set)                  jump_buf_d = 1'b1;
    end else if (state_q == ST_DEAD && restart_i) begin
      jump_buf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) jump_buf_q <= 1'b0;
    else          jump_buf_q <= jump_buf_d;
  end
`else
  assign rejump = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    vel_d    = vel_q;
    adv_dist = 1'b0;
    adv_leg  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (jump_edge) state_d = ST_RUN;
      end
      ST_RUN, ST_SLIDE: begin
        if (hit_i) begin
          state_d = ST_DEAD;
        end else begin
          adv_dist = frame_tick_i;
          adv_leg  = frame_tick_i;
          if (jump_edge) begin
            state_d = ST_JUMP;
            vel_d   = V0;
          end else begin
            state_d = btn_slide_i ? ST_SLIDE : ST_RUN;
          end
        end
      end
      ST_JUMP: begin
        if (hit_i) begin
          state_d = ST_DEAD;
        end else if (frame_tick_i) begin
          adv_dist = 1'b1;
          vel_d    = vel_q - 6'sd1;
          if (landing) begin
            y_d = GROUND;
            if (rejump) begin
              vel_d   = V0;
              state_d = ST_JUMP;
            end else begin
              vel_d   = '0;
              state_d = btn_slide_i ? ST_SLIDE : ST_RUN;
            end
          end else if (y_next[10]) begin
            y_d = '0;
          end else begin
            y_d = y_next[9:0];
          end
        end
      end
      ST_DEAD: begin
        if (restart_i) begin
          state_d = ST_IDLE;
          y_d     = GROUND;
          vel_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dist_d    = dist_q;
    leg_cnt_d = leg_cnt_q;
    leg_d     = leg_q;
    if (state_q == ST_DEAD && restart_i) begin
      dist_d    = '0;
      leg_cnt_d = '0;
      leg_d     = 1'b0;
    end else begin
      if (adv_dist && dist_q != 16'hFFFF) dist_d = dist_q + 16'd1;
      if (adv_leg) begin
        if (leg_cnt_q == LEG_LAST) begin
          leg_cnt_d = '0;
          leg_d     = ~leg_q;
        end else begin
          leg_cnt_d = leg_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      y_q         <= GROUND;
      vel_q       <= '0;
      leg_cnt_q   <= '0;
      leg_q       <= 1'b0;
      dist_q      <= '0;
      jump_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      leg_cnt_q   <= leg_cnt_d;
      leg_q       <= leg_d;
      dist_q      <= dist_d;
      jump_prev_q <= btn_jump_i;
    end
  end

  assign goose_y_o   = y_q;
  assign pose_o      = state_q[1:0];
  assign leg_phase_o = leg_q;
  assign playing_o   = (state_q == ST_RUN) || (state_q == ST_SLIDE) || (state_q == ST_JUMP);
  assign game_over_o = (state_q == ST_DEAD);
  assign distance_o  = dist_q;
endmodule
